seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider -- unsigned 20-bit by 16-bit restoring divider, one quotient bit
// per clock, MSB first.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   division request, sampled only while idle
//   dividend     in  20   unsigned dividend
//   divisor      in  16   unsigned divisor
//   busy         out  1   high while iterating (RUN)
//   done         out  1   one-cycle pulse when results are valid
//   quotient     out 20   unsigned quotient
//   remainder    out 16   unsigned remainder
//   div_by_zero  out  1   captured divisor was zero; held with the results
//
// A non-zero divisor takes 20 RUN cycles followed by one DONE cycle. A zero
// divisor skips RUN and reports quotient all-ones with the low 16 dividend
// bits as remainder. Results stay on the outputs until the next accepted start.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [19:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [19:0] dvd_q,   dvd_d;   // dividend, shifted left so bit 19 is the next bit in
  logic [15:0] dsr_q,   dsr_d;
  logic [15:0] rem_q,   rem_d;   // settled remainder, always < divisor
  logic [19:0] quo_q,   quo_d;   // quotient bits shift in at the LSB
  logic        dbz_q,   dbz_d;

  // The shifted partial remainder needs 17 bits: a 16-bit remainder below the
  // divisor, shifted left with a new bit, can reach 2*divisor-1.
  logic [16:0] rem_sh;
  logic [16:0] rem_sub;
  logic        fits;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[19]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    fits    = (rem_sh >= {1'b0, dsr_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != 16'd0) begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = 16'd0;
            quo_d   = 20'd0;
            dbz_d   = 1'b0;
            cnt_d   = 5'd19;
            state_d = RUN;
          end else begin
            dvd_d   = 20'd0;
            dsr_d   = 16'd0;
            rem_d   = dividend[15:0];
            quo_d   = 20'hFFFFF;
            dbz_d   = 1'b1;
            cnt_d   = 5'd0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[18:0], 1'b0};
        if (fits) begin
          // rem_sub < divisor here, so the top bit is always zero.
          rem_d = rem_sub[15:0];
          quo_d = {quo_q[18:0], 1'b1};
        end else begin
          rem_d = rem_sh[15:0];
          quo_d = {quo_q[18:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 20'd0;
      dsr_q   <= 16'd0;
      rem_q   <= 16'd0;
      quo_q   <= 20'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [19:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one division and follow it to completion. elat is the number of
  // edges from the accepting edge up to and including the edge at which done
  // is first sampled high (21 for a normal divide, 1 for divide-by-zero).
  task automatic do_op(input string tag, input logic [19:0] a, input logic [15:0] b,
                       input logic [19:0] eq, input logic [15:0] er, input logic ez,
                       input int elat);
    int  c;
    int  nbusy;
    bit  seen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Operands change right after acceptance; the result must not care.
    dividend = 20'($urandom);
    divisor  = 16'($urandom);
    c     = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (c < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      tick();
      c++;
    end
    check({tag, "_lat"},  seen ? c : 0, elat);
    check({tag, "_busy"}, nbusy, elat - 1);
    check({tag, "_q"},    quotient, eq);
    check({tag, "_r"},    remainder, er);
    check({tag, "_dbz"},  div_by_zero, ez);
    tick();
    check({tag, "_pulse"}, done, 1'b0);
    tick();
    check({tag, "_holdq"}, quotient, eq);
    check({tag, "_holdr"}, remainder, er);
    check({tag, "_holdz"}, div_by_zero, ez);
  endtask

  initial begin
    int          c;
    int          dones;
    int          dc;
    logic [19:0] gq;
    logic [15:0] gr;
    logic [19:0] ra;
    logic [15:0] rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 20'd0;
    divisor  = 16'd0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q",    quotient, 20'd0);
    check("rst_r",    remainder, 16'd0);
    check("rst_dbz",  div_by_zero, 1'b0);

    // start held during reset must be ignored
    start    = 1'b1;
    dividend = 20'd100;
    divisor  = 16'd5;
    tick();
    tick();
    check("rststart_busy", busy, 1'b0);
    check("rststart_done", done, 1'b0);
    rst_n = 1'b1;
    // first edge with rst_n high accepts
    do_op("first", 20'd100, 16'd5, 20'd20, 16'd0, 1'b0, 21);

    do_op("vec1m",  20'hF4240, 16'h03E8, 20'h003E8, 16'h0000, 1'b0, 21);
    do_op("vecmax", 20'hFFFFF, 16'hFFFF, 20'h00010, 16'h000F, 1'b0, 21);
    do_op("vec5_7", 20'd5,     16'd7,    20'd0,     16'd5,    1'b0, 21);
    do_op("div1",   20'hABCDE, 16'd1,    20'hABCDE, 16'd0,    1'b0, 21);
    do_op("dbz",    20'h12345, 16'h0000, 20'hFFFFF, 16'h2345, 1'b1, 1);
    // div_by_zero must clear on the next accepted start
    do_op("afterdbz", 20'd1000, 16'd3, 20'd333, 16'd1, 1'b0, 21);

    // start pulses during RUN and DONE with new operands are ignored
    dividend = 20'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    dc    = 0;
    gq    = 20'd0;
    gr    = 16'd0;
    for (c = 1; c < 30; c++) begin
      if (done) begin
        dones++;
        dc = c;
        gq = quotient;
        gr = remainder;
      end
      start = (c == 5) || (c == 21);
      if (start) begin
        dividend = 20'hFFFFF;
        divisor  = 16'd1;
      end
      tick();
    end
    start = 1'b0;
    check("ign_dones", dones, 1);
    check("ign_lat",   dc, 21);
    check("ign_q",     gq, 20'd142);
    check("ign_r",     gr, 16'd6);
    check("ign_idle",  busy, 1'b0);
    check("ign_holdq", quotient, 20'd142);

    // reset in the middle of RUN
    dividend = 20'hF4240;
    divisor  = 16'h03E8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (c = 1; c < 10; c++) tick();
    check("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_q",    quotient, 20'd0);
    check("mid_r",    remainder, 16'd0);
    check("mid_dbz",  div_by_zero, 1'b0);
    rst_n = 1'b1;
    dones = 0;
    for (c = 0; c < 25; c++) begin
      if (done || busy) dones++;
      tick();
    end
    check("mid_quiet", dones, 0);
    do_op("mid_fresh", 20'hF4240, 16'h03E8, 20'h003E8, 16'h0000, 1'b0, 21);

    // reset right after a divide-by-zero result clears the held flag
    do_op("dbz2", 20'h0FFFF, 16'h0000, 20'hFFFFF, 16'hFFFF, 1'b1, 1);
    rst_n = 1'b0;
    tick();
    check("dbz2_rst_z", div_by_zero, 1'b0);
    check("dbz2_rst_q", quotient, 20'd0);
    rst_n = 1'b1;
    tick();

    // random operand pairs against the reference division
    for (int i = 0; i < 300; i++) begin
      ra = 20'($urandom_range(0, 20'hFFFFF));
      if (i % 4 == 0) rb = 16'($urandom_range(1, 16));
      else            rb = 16'($urandom_range(1, 16'hFFFF));
      do_op("rand", ra, rb, 20'(ra / 20'(rb)), 16'(ra % 20'(rb)), 1'b0, 21);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
